// File: rtl/reg_file_wr_arbiter.sv
// reg_file_wr_arbiter: round-robin merge of ALU (A) and load (B) writebacks onto one reg_file write port
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   a_valid/a_ready/a_addr/a_data   requester A push handshake and entry
//   b_valid/b_ready/b_addr/b_data   requester B push handshake and entry
//   wren/wr/wd               registered reg_file write port
//   q_addr/q_pending         combinational in-flight destination lookup
//   idle                     both FIFOs empty and no write this cycle
module reg_file_wr_arbiter #(
  parameter int DEPTH = 2,
  parameter int AW = 5,
  parameter int DW = 32,
  parameter bit DROP_X0 = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          a_valid,
  output logic          a_ready,
  input  logic [AW-1:0] a_addr,
  input  logic [DW-1:0] a_data,
  input  logic          b_valid,
  output logic          b_ready,
  input  logic [AW-1:0] b_addr,
  input  logic [DW-1:0] b_data,
  output logic          wren,
  output logic [AW-1:0] wr,
  output logic [DW-1:0] wd,
  input  logic [AW-1:0] q_addr,
  output logic          q_pending,
  output logic          idle
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  logic [AW+DW-1:0] a_mem [DEPTH];
  logic [AW+DW-1:0] b_mem [DEPTH];
  logic [PW-1:0] a_wp, a_rp, b_wp, b_rp, a_cnt, b_cnt;
  logic a_ne, b_ne, a_push, b_push, gnt_a, gnt_b, last_b, hit;
  logic [AW+DW-1:0] sel;
  assign a_ne = a_wp != a_rp;
  assign b_ne = b_wp != b_rp;
  // pointers carry an extra wrap bit: full when wrap bits differ and indices match
  assign a_ready = !((a_wp[IW] != a_rp[IW]) && (a_wp[IW-1:0] == a_rp[IW-1:0]));
  assign b_ready = !((b_wp[IW] != b_rp[IW]) && (b_wp[IW-1:0] == b_rp[IW-1:0]));
  assign a_push = a_valid && a_ready;
  assign b_push = b_valid && b_ready;
  // last_b resets to 1 so A wins the first tie
  assign gnt_a = a_ne && (!b_ne || last_b);
  assign gnt_b = b_ne && !gnt_a;
  assign sel = gnt_a ? a_mem[a_rp[IW-1:0]] : b_mem[b_rp[IW-1:0]];
  assign a_cnt = a_wp - a_rp;
  assign b_cnt = b_wp - b_rp;
  // slot i is live when its distance from the read pointer is below the fill count
  always_comb begin
    hit = wren && (wr == q_addr);
    for (int i = 0; i < DEPTH; i++) begin
      hit = hit | (({1'b0, IW'(i) - a_rp[IW-1:0]} < a_cnt) && (a_mem[i][AW+DW-1:DW] == q_addr));
      hit = hit | (({1'b0, IW'(i) - b_rp[IW-1:0]} < b_cnt) && (b_mem[i][AW+DW-1:DW] == q_addr));
    end
  end
  assign q_pending = hit && !(DROP_X0 && (q_addr == '0));
  assign idle = !a_ne && !b_ne && !wren;
  always_ff @(posedge clk) begin
    if (a_push) a_mem[a_wp[IW-1:0]] <= {a_addr, a_data};
    if (b_push) b_mem[b_wp[IW-1:0]] <= {b_addr, b_data};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_wp <= '0;
      a_rp <= '0;
      b_wp <= '0;
      b_rp <= '0;
      last_b <= 1'b1;
      wren <= 1'b0;
      wr <= '0;
      wd <= '0;
    end else begin
      if (a_push) a_wp <= a_wp + PW'(1);
      if (b_push) b_wp <= b_wp + PW'(1);
      if (gnt_a) a_rp <= a_rp + PW'(1);
      if (gnt_b) b_rp <= b_rp + PW'(1);
      // round-robin state only moves on a genuine tie
      if (a_ne && b_ne) last_b <= gnt_b;
      wren <= (gnt_a || gnt_b) && !(DROP_X0 && (sel[AW+DW-1:DW] == '0));
      if (gnt_a || gnt_b) {wr, wd} <= sel;
    end
  end
endmodule
